// File: rtl/resp_framer.sv
// resp_framer: serialises a response request into cmd, len, payload, CR, NL bytes
// for a byte-wide UART transmitter, waiting out the UART busy flag between bytes.
module resp_framer #(
    parameter int MAX_BYTES = 16,
    parameter int LEN_BITS  = 5,
    parameter int DATA_BITS = 8 * MAX_BYTES
) (
    input  logic                 sys_clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 req,
    input  logic [7:0]           req_cmd,
    input  logic [LEN_BITS-1:0]  req_len,
    input  logic [DATA_BITS-1:0] req_data,
    output logic                 busy,
    output logic                 done,
    output logic                 dropped,
    output logic                 transmit,
    output logic [7:0]           tx_byte,
    input  logic                 is_transmitting
);
    typedef enum logic [2:0] {IDLE, LOAD, SEND, GUARD, WAIT, FIN} state_t;
    localparam logic [LEN_BITS-1:0] MAX_LEN = LEN_BITS'(MAX_BYTES);
    localparam logic [LEN_BITS:0]   ONE     = (LEN_BITS+1)'(1);
    localparam logic [LEN_BITS:0]   TWO     = (LEN_BITS+1)'(2);
    localparam logic [LEN_BITS:0]   THREE   = (LEN_BITS+1)'(3);
    state_t               state_q, state_d;
    logic [7:0]           cmd_q, cmd_d;
    logic [LEN_BITS-1:0]  len_q, len_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic [LEN_BITS:0]    idx_q, idx_d;
    logic                 busy_q, busy_d, done_q, done_d;
    logic                 dropped_q, dropped_d, transmit_q, transmit_d;
    logic [7:0]           tx_byte_q, tx_byte_d;
    logic [LEN_BITS:0]    len_ext, pay_idx;
    logic [7:0]           sel_byte;
    always_comb begin
        len_ext    = {1'b0, len_q};
        pay_idx    = idx_q - TWO;
        sel_byte   = idx_q == '0 ? cmd_q
                   : idx_q == ONE ? 8'(len_q)
                   : idx_q < len_ext + TWO ? 8'(data_q >> {pay_idx, 3'b000})
                   : idx_q == len_ext + TWO ? 8'h0D : 8'h0A;
        state_d    = state_q;
        cmd_d      = cmd_q;
        len_d      = len_q;
        data_d     = data_q;
        idx_d      = idx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        transmit_d = 1'b0;
        tx_byte_d  = tx_byte_q;
        dropped_d  = req && state_q != IDLE;
        case (state_q)
            IDLE: if (req) begin
                cmd_d   = req_cmd;
                len_d   = req_len > MAX_LEN ? MAX_LEN : req_len;
                data_d  = req_data;
                idx_d   = '0;
                busy_d  = 1'b1;
                state_d = LOAD;
            end
            LOAD: begin
                tx_byte_d = sel_byte;
                // a foreign transmission may own the UART; hold the strobe back
                if (!is_transmitting) begin
                    transmit_d = 1'b1;
                    state_d    = SEND;
                end
            end
            SEND:  state_d = GUARD;
            GUARD: state_d = WAIT;
            WAIT: if (!is_transmitting) begin
                if (idx_q == len_ext + THREE) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = FIN;
                end else begin
                    idx_d   = idx_q + ONE;
                    state_d = LOAD;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d    = IDLE;
            idx_d      = '0;
            busy_d     = 1'b0;
            done_d     = 1'b0;
            dropped_d  = 1'b0;
            transmit_d = 1'b0;
        end
    end
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cmd_q      <= '0;
            len_q      <= '0;
            data_q     <= '0;
            idx_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dropped_q  <= 1'b0;
            transmit_q <= 1'b0;
            tx_byte_q  <= '0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            len_q      <= len_d;
            data_q     <= data_d;
            idx_q      <= idx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            dropped_q  <= dropped_d;
            transmit_q <= transmit_d;
            tx_byte_q  <= tx_byte_d;
        end
    end
    assign busy     = busy_q;
    assign done     = done_q;
    assign dropped  = dropped_q;
    assign transmit = transmit_q;
    assign tx_byte  = tx_byte_q;
endmodule

// File: tb/tb_resp_framer.sv
// tb_resp_framer: randomized frame requests against a queue-based frame model,
// with a UART model that stays busy 10 cycles after each strobe.
module tb_resp_framer;
    localparam int MAX_BYTES = 16;
    localparam int LEN_BITS  = 5;
    localparam int DATA_BITS = 8 * MAX_BYTES;
    logic sys_clk = 0, rst_n = 0, flush = 0, req = 0, foreign = 0;
    logic [7:0] req_cmd = 0;
    logic [LEN_BITS-1:0] req_len = 0;
    logic [DATA_BITS-1:0] req_data = 0;
    logic busy, done, dropped, transmit, is_transmitting;
    logic [7:0] tx_byte;
    int checks = 0, errors = 0;
    int uart_cnt = 0, done_cnt = 0, overlaps = 0, busy_gap = 0;
    bit track_busy = 0;
    logic [7:0] got_q[$], exp_q[$];

    resp_framer #(.MAX_BYTES(MAX_BYTES), .LEN_BITS(LEN_BITS), .DATA_BITS(DATA_BITS)) dut (
        .sys_clk(sys_clk), .rst_n(rst_n), .flush(flush), .req(req), .req_cmd(req_cmd),
        .req_len(req_len), .req_data(req_data), .busy(busy), .done(done), .dropped(dropped),
        .transmit(transmit), .tx_byte(tx_byte), .is_transmitting(is_transmitting));

    always #5 sys_clk = ~sys_clk;
    assign is_transmitting = foreign || uart_cnt > 0;
    always @(posedge sys_clk) uart_cnt <= transmit ? 10 : (uart_cnt > 0 ? uart_cnt - 1 : 0);

    always @(negedge sys_clk) begin
        if (transmit) begin
            got_q.push_back(tx_byte);
            if (is_transmitting) overlaps++;
        end
        if (done) done_cnt++;
        if (track_busy) begin
            if (done) track_busy = 0;
            else if (!busy) busy_gap++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [DATA_BITS-1:0] rand_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_frame(input logic [7:0] c, input int l, input logic [DATA_BITS-1:0] d);
        int n;
        n = l > MAX_BYTES ? MAX_BYTES : l;
        exp_q.delete();
        exp_q.push_back(c);
        exp_q.push_back(8'(n));
        for (int k = 0; k < n; k++) exp_q.push_back(d[8*k +: 8]);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    function automatic int first_diff();
        if (got_q.size() != exp_q.size()) return -2;
        foreach (got_q[k]) if (got_q[k] !== exp_q[k]) return k;
        return -1;
    endfunction

    task automatic clear_mon();
        for (int i = 0; i < 40 && is_transmitting; i++) @(negedge sys_clk);
        @(negedge sys_clk);
        got_q.delete();
        done_cnt = 0; overlaps = 0; busy_gap = 0; track_busy = 0;
    endtask

    task automatic send_req(input logic [7:0] c, input int l, input logic [DATA_BITS-1:0] d);
        @(negedge sys_clk);
        req_cmd = c; req_len = LEN_BITS'(l); req_data = d; req = 1;
        @(negedge sys_clk);
        req = 0; track_busy = 1;
        req_cmd = 8'($urandom); req_len = LEN_BITS'($urandom); req_data = rand_data();
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge sys_clk);
            if (done) begin ok = 1; return; end
        end
    endtask

    task automatic check_frame(input string name, input bit ok);
        int d;
        checks++;
        if (!ok) begin errors++; $display("FAIL %s done_timeout: done never rose, expected 1", name); end
        @(negedge sys_clk);
        d = first_diff();
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL %s bytes: diff at %0d, got %0d bytes, expected %0d bytes", name, d, got_q.size(), exp_q.size());
        end
        checks++;
        if (done_cnt !== 1) begin errors++; $display("FAIL %s done_count: got %0d expected 1", name, done_cnt); end
        checks++;
        if (busy_gap !== 0) begin errors++; $display("FAIL %s busy_gap: got %0d cycles low, expected 0", name, busy_gap); end
        checks++;
        if (overlaps !== 0) begin errors++; $display("FAIL %s overlap: got %0d strobes during UART busy, expected 0", name, overlaps); end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge sys_clk);
        checks++;
        if ({busy, done, dropped, transmit, tx_byte} !== 12'h0) begin
            errors++; $display("FAIL reset_hold: got %h expected 000", {busy, done, dropped, transmit, tx_byte});
        end
        rst_n = 1;
        repeat (2) @(negedge sys_clk);
        checks++;
        if ({busy, done, dropped, transmit, tx_byte} !== 12'h0) begin
            errors++; $display("FAIL reset_release: got %h expected 000", {busy, done, dropped, transmit, tx_byte});
        end
    endtask

    task automatic test_basic();
        bit ok;
        clear_mon();
        model_frame(8'h04, 4, 128'hDEADBEEF);
        @(negedge sys_clk);
        req_cmd = 8'h04; req_len = 4; req_data = 128'hDEADBEEF; req = 1;
        @(negedge sys_clk);
        req = 0; track_busy = 1; req_data = rand_data();
        checks++;
        if (busy !== 1 || transmit !== 0) begin
            errors++; $display("FAIL basic_load: got busy=%b transmit=%b expected 1 0", busy, transmit);
        end
        @(negedge sys_clk);
        checks++;
        if (transmit !== 1 || tx_byte !== 8'h04) begin
            errors++; $display("FAIL basic_latency: got transmit=%b tx_byte=%h expected 1 04", transmit, tx_byte);
        end
        wait_done(400, ok);
        check_frame("basic", ok);
    endtask

    task automatic test_zero_len();
        bit ok;
        clear_mon();
        model_frame(8'h05, 0, 0);
        send_req(8'h05, 0, rand_data());
        wait_done(200, ok);
        check_frame("zero_len", ok);
    endtask

    task automatic test_clamp();
        bit ok;
        logic [DATA_BITS-1:0] d;
        for (int k = 0; k < MAX_BYTES; k++) d[8*k +: 8] = k < 4 ? (k % 2 ? 8'h0A : 8'h0D) : 8'($urandom);
        clear_mon();
        model_frame(8'h06, 20, d);
        send_req(8'h06, 20, d);
        wait_done(600, ok);
        check_frame("clamp", ok);
        checks++;
        if (got_q.size() < 2 || got_q[1] !== 8'h10) begin
            errors++; $display("FAIL clamp_len_byte: got %0d bytes, len byte %h expected 10", got_q.size(), got_q.size() > 1 ? got_q[1] : 8'hxx);
        end
    endtask

    task automatic test_random();
        bit ok;
        logic [7:0] c;
        int l;
        logic [DATA_BITS-1:0] d;
        for (int n = 0; n < 6; n++) begin
            c = 8'($urandom); l = $urandom_range(0, 20); d = rand_data();
            clear_mon();
            model_frame(c, l, d);
            send_req(c, l, d);
            wait_done(600, ok);
            check_frame($sformatf("random%0d", n), ok);
        end
    endtask

    task automatic test_overlap();
        bit ok;
        logic [DATA_BITS-1:0] d;
        d = rand_data();
        clear_mon();
        model_frame(8'h21, 3, d);
        send_req(8'h21, 3, d);
        repeat (4) @(negedge sys_clk);
        req_cmd = 8'h99; req_len = 7; req_data = rand_data(); req = 1;
        @(negedge sys_clk);
        req = 0;
        checks++;
        if (dropped !== 1 || busy !== 1) begin
            errors++; $display("FAIL overlap_drop: got dropped=%b busy=%b expected 1 1", dropped, busy);
        end
        wait_done(400, ok);
        check_frame("overlap", ok);
        clear_mon();
        model_frame(8'h22, 0, 0);
        send_req(8'h22, 0, 0);
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge sys_clk);
            if (done) begin ok = 1; req_cmd = 8'h77; req_len = 2; req = 1; end
        end
        @(negedge sys_clk);
        req = 0;
        checks++;
        if (dropped !== 1 || busy !== 0) begin
            errors++; $display("FAIL fin_drop: got dropped=%b busy=%b expected 1 0", dropped, busy);
        end
        repeat (20) @(negedge sys_clk);
        checks++;
        if (!ok || got_q.size() != 4 || done_cnt != 1) begin
            errors++; $display("FAIL fin_frame: got done_seen=%b bytes=%0d dones=%0d expected 1 4 1", ok, got_q.size(), done_cnt);
        end
    endtask

    task automatic test_flush();
        int n, late;
        n = 0; late = 0;
        clear_mon();
        send_req(8'h31, 8, rand_data());
        for (int i = 0; i < 200 && n < 3; i++) begin
            @(negedge sys_clk);
            if (transmit) n++;
        end
        flush = 1; req = 1;
        @(negedge sys_clk);
        flush = 0; req = 0;
        checks++;
        if (n != 3 || busy !== 0 || transmit !== 0 || dropped !== 0) begin
            errors++; $display("FAIL flush_idle: got strobes=%0d busy=%b transmit=%b dropped=%b expected 3 0 0 0", n, busy, transmit, dropped);
        end
        for (int i = 0; i < 60; i++) begin
            @(negedge sys_clk);
            if (transmit || busy) late++;
        end
        checks++;
        if (late != 0 || done_cnt != 0 || got_q.size() != 3) begin
            errors++; $display("FAIL flush_quiet: got late=%0d dones=%0d bytes=%0d expected 0 0 3", late, done_cnt, got_q.size());
        end
        clear_mon();
        flush = 1; req = 1; req_len = 2;
        @(negedge sys_clk);
        flush = 0; req = 0;
        late = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge sys_clk);
            if (transmit || busy || dropped) late++;
        end
        checks++;
        if (late != 0) begin errors++; $display("FAIL flush_req_priority: got %0d active cycles expected 0", late); end
    endtask

    task automatic test_reset_mid();
        int n, sz;
        n = 0;
        clear_mon();
        send_req(8'h41, 4, rand_data());
        for (int i = 0; i < 200 && n < 2; i++) begin
            @(negedge sys_clk);
            if (transmit) n++;
        end
        repeat (2) @(negedge sys_clk);
        checks++;
        if (busy !== 1 || tx_byte !== 8'h04) begin
            errors++; $display("FAIL reset_mid_pre: got busy=%b tx_byte=%h expected 1 04", busy, tx_byte);
        end
        #2 rst_n = 0;
        #1;
        checks++;
        if ({busy, done, dropped, transmit, tx_byte} !== 12'h0) begin
            errors++; $display("FAIL reset_mid_async: got %h expected 000", {busy, done, dropped, transmit, tx_byte});
        end
        @(negedge sys_clk);
        rst_n = 1;
        sz = got_q.size();
        repeat (40) @(negedge sys_clk);
        checks++;
        if (got_q.size() != sz || done_cnt != 0 || busy !== 0) begin
            errors++; $display("FAIL reset_mid_quiet: got bytes=%0d dones=%0d busy=%b expected %0d 0 0", got_q.size(), done_cnt, busy, sz);
        end
    endtask

    task automatic test_prebusy();
        bit ok;
        int early;
        logic [DATA_BITS-1:0] d;
        early = 0; d = rand_data();
        clear_mon();
        model_frame(8'h51, 2, d);
        foreign = 1;
        send_req(8'h51, 2, d);
        for (int i = 0; i < 6; i++) begin
            @(negedge sys_clk);
            if (transmit) early++;
        end
        foreign = 0;
        checks++;
        if (early != 0) begin errors++; $display("FAIL prebusy_hold: got %0d strobes while UART busy expected 0", early); end
        wait_done(300, ok);
        check_frame("prebusy", ok);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_clamp();
        test_random();
        test_overlap();
        test_flush();
        test_reset_mid();
        test_prebusy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/resp_framer.md
Name: resp_framer

Overview:
- Transmit-side framer for the host command link; the mirror of the CR/NL-terminated command receiver.
- Accepts one response request (command echo byte plus up to MAX_BYTES payload bytes) from the command processor.
- Serialises it byte-by-byte into the UART transmitter as: cmd, len, payload[0..len-1], CR (0x0D), NL (0x0A).
- Implements PRINT readback and richer command acknowledgements; the len byte lets the host parse payloads that contain 0x0D 0x0A.

Parameters:
- MAX_BYTES, 16, maximum payload bytes per frame.
- LEN_BITS, 5, width of req_len; must hold MAX_BYTES.
- DATA_BITS, 8*MAX_BYTES, width of the flattened payload bus.

Ports:
- sys_clk  in  1  communication clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous abort, driven from the UART idle-timeout reset.
- req  in  1  one-cycle request strobe.
- req_cmd  in  8  command byte to echo.
- req_len  in  LEN_BITS  payload byte count, 0..MAX_BYTES.
- req_data  in  DATA_BITS  payload; byte k = req_data[8k+7:8k], byte 0 is sent first.
- busy  out  1  high from the accepted req until the frame completes.
- done  out  1  one-cycle pulse after NL has left the UART.
- dropped  out  1  one-cycle pulse when req arrives while busy.
- transmit  out  1  one-cycle strobe to the UART.
- tx_byte  out  8  byte presented with transmit.
- is_transmitting  in  1  UART busy flag.

Behaviour:
- Reset (rst_n low, async): state IDLE; busy=0, done=0, dropped=0, transmit=0, tx_byte=0; byte index=0; latched frame cleared.
- Accepting a request (IDLE, req=1):
  - Latch req_cmd, clamped length, and req_data into internal registers. req_data may change after the accept cycle.
  - Length clamp: min(req_len, MAX_BYTES).
  - busy goes high the next cycle.
  - Frame length = clamped len + 4 bytes.
- States:
  - IDLE: wait for req.
  - LOAD: select the next frame byte into tx_byte.
  - SEND: transmit=1 for exactly one cycle, tx_byte stable.
  - GUARD: one cycle that ignores is_transmitting; covers the UART's one-cycle flag latency.
  - WAIT: hold until is_transmitting=0.
  - Leaving WAIT: go to LOAD if bytes remain; otherwise go to FIN.
  - FIN: done=1 for one cycle, busy=0, return to IDLE.
- Byte sequence, by index i:
  - i=0: cmd
  - i=1: clamped len (zero-extended to 8 bits)
  - i=2..len+1: payload[i-2]
  - i=len+2: 0x0D
  - i=len+3: 0x0A
- Latency: first transmit strobe is 2 cycles after the accepted req (LOAD, then SEND).
- Inter-byte gap: 3 cycles plus UART busy time.
- len=0: frame is cmd, 0x00, CR, NL (4 bytes).
- Entering SEND while is_transmitting is already high (a foreign transmission): stay in LOAD until it is low. transmit is never asserted while is_transmitting=1.
- req while busy: ignored; dropped pulses 1 cycle later; the frame in flight is unaffected.
- req in the same cycle as FIN: treated as busy, so it is dropped.
- flush (any state):
  - Next cycle returns to IDLE, busy=0, transmit=0, no done pulse.
  - A byte already handed to the UART completes on the line.
  - flush has priority over a simultaneous req; that req is discarded and dropped is not pulsed.
- rst_n asserted mid-frame: immediate return to reset values; no further transmit strobes.
- Outputs are registered; there is no combinational path from inputs to transmit or tx_byte.

Test Plan:
- Model: UART raises is_transmitting 1 cycle after transmit and holds it 10 cycles.
- Basic PRINT frame: req_cmd=0x04, req_len=4, req_data[31:0]=0xDEADBEEF -> tx bytes 04,04,EF,BE,AD,DE,0D,0A; 8 transmit strobes; done once; busy high throughout.
- Zero length: req_cmd=0x05, req_len=0 -> bytes 05,00,0D,0A; done after the 4th byte leaves.
- Clamp and payload with CR/NL: req_len=20, MAX_BYTES=16, payload bytes 0x0D,0x0A,... -> len byte 0x10; 16 payload bytes sent verbatim; 20 bytes total.
- Overlap and simultaneity: second req 5 cycles into a frame -> dropped pulse; first frame completes intact. req coincident with the FIN cycle -> dropped.
- Flush and reset mid-frame:
  - flush after byte 3 -> IDLE next cycle, no further strobes, no done.
  - rst_n low during WAIT -> all outputs 0 asynchronously.
- Pre-busy UART: is_transmitting held high at accept for 7 cycles -> first transmit strobe only after it falls; strobe never overlaps is_transmitting=1.
